// File: rtl/ref_clk_tap_switch.sv
// ref_clk_tap_switch
//   One-hot transmission-gate enable driver for the reference-clock divider
//   taps. A tap change first turns every gate off for BBM_CYCLES cycles.
//   It then enables the new tap and waits SETTLE_CYCLES cycles before it
//   reports completion. Two taps are therefore never shorted together.
// Ports:
//   clk           block clock
//   rstn          synchronous active-low reset
//   ref_clk_sel   requested tap index (level-sampled)
//   err_clr       clears the sticky sel_err flag
//   tgate_control one-hot tgate enables (all-zero during the break)
//   cur_sel       index of the tap currently enabled / being made
//   busy          high from switch start until switch_done
//   switch_done   one-cycle pulse at the end of the settle window
//   sel_err       sticky flag, an out-of-range select was seen
module ref_clk_tap_switch #(
  parameter int unsigned NUM_TAPS      = 5,
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned DEFAULT_TAP   = 1,
  parameter int unsigned BBM_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [SEL_W-1:0]    ref_clk_sel,
  input  logic                err_clr,
  output logic [NUM_TAPS-1:0] tgate_control,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                busy,
  output logic                switch_done,
  output logic                sel_err
);

  localparam int unsigned CNT_MAX = (BBM_CYCLES > SETTLE_CYCLES) ? BBM_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned SEL_N   = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_TAP);

  // Per-code validity table; avoids a constant compare when NUM_TAPS == 2**SEL_W.
  function automatic logic [SEL_N-1:0] f_range_mask();
    logic [SEL_N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SEL_N; i++) m[i] = (i < NUM_TAPS);
    return m;
  endfunction

  localparam logic [SEL_N-1:0] RANGE_MASK = f_range_mask();

  function automatic logic [NUM_TAPS-1:0] f_onehot(input logic [SEL_W-1:0] idx);
    return NUM_TAPS'(1) << idx;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_SETTLE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [SEL_W-1:0]    r_target;
  logic [SEL_W-1:0]    r_cur;
  logic [NUM_TAPS-1:0] r_tgate;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_in_range;
  logic [SEL_W-1:0]    w_tgt;

  // Out-of-range requests fall back to the default tap.
  assign w_in_range = RANGE_MASK[ref_clk_sel];
  assign w_tgt      = w_in_range ? ref_clk_sel : DEF_SEL;

  // Break-before-make sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_target <= DEF_SEL;
      r_cur    <= DEF_SEL;
      r_tgate  <= f_onehot(DEF_SEL);
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A set wins over a clear in the same cycle.
      if (!w_in_range)  r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_tgt != r_cur) begin
            r_target <= w_tgt;
            r_tgate  <= '0;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(BBM_CYCLES - 1);
            r_state  <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (r_cnt == '0) begin
            r_tgate <= f_onehot(r_target);
            r_cur   <= r_target;
            r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tgate_control = r_tgate;
  assign cur_sel       = r_cur;
  assign busy          = r_busy;
  assign switch_done   = r_done;
  assign sel_err       = r_err;

endmodule

// File: tb/tb_ref_clk_tap_switch.sv
// Bench for ref_clk_tap_switch: timeline model plus directed literal checks on the
// default configuration, and invariant checks on an 8-tap, BBM=1, SETTLE=1 instance.
module tb_ref_clk_tap_switch;

  localparam int NT = 5, DEF = 1, BBM = 4, SET = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] sel = 3'd1;
  logic       clr = 1'b0;
  logic [4:0] tg;
  logic [2:0] cur;
  logic       busy, done, err;

  logic [2:0] sel8 = 3'd1;
  logic [7:0] tg8;
  logic [2:0] cur8;
  logic       busy8, done8, err8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ref_clk_tap_switch #(.NUM_TAPS(5), .SEL_W(3), .DEFAULT_TAP(1), .BBM_CYCLES(4), .SETTLE_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn), .ref_clk_sel(sel), .err_clr(clr),
    .tgate_control(tg), .cur_sel(cur), .busy(busy), .switch_done(done), .sel_err(err));

  ref_clk_tap_switch #(.NUM_TAPS(8), .SEL_W(3), .DEFAULT_TAP(1), .BBM_CYCLES(1), .SETTLE_CYCLES(1)) dut8 (
    .clk(clk), .rstn(rstn), .ref_clk_sel(sel8), .err_clr(1'b0),
    .tgate_control(tg8), .cur_sel(cur8), .busy(busy8), .switch_done(done8), .sel_err(err8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int map_sel(input int s);
    return (s < NT) ? s : DEF;
  endfunction

  // Timeline model: a switch started at edge t0 is dark for edges t0..t0+BBM-1,
  // makes at t0+BBM and finishes at t0+BBM+SET.
  int   cyc = 0;
  bit   m_valid = 0, m_act = 0, m_done = 0, m_err = 0, m_rst_edge = 0;
  int   m_t0 = 0, m_tgt = DEF, m_cur = DEF;
  logic [4:0] m_tg = 5'b00010;

  always @(posedge clk) begin
    m_rst_edge = !rstn;
    if (!rstn) begin
      m_valid = 1; m_act = 0; m_done = 0; m_err = 0; m_cur = DEF; m_tgt = DEF;
    end else begin
      m_done = 0;
      if (int'(sel) >= NT) m_err = 1;
      else if (clr) m_err = 0;
      if (m_act) begin
        if (cyc - m_t0 == BBM) m_cur = m_tgt;
        if (cyc - m_t0 == BBM + SET) begin m_act = 0; m_done = 1; end
      end else if (map_sel(int'(sel)) != m_cur) begin
        m_act = 1; m_t0 = cyc; m_tgt = map_sel(int'(sel));
      end
    end
    m_tg = (m_act && (cyc - m_t0) < BBM) ? 5'b0 : 5'(1 << m_cur);
    cyc++;
  end

  // Per-cycle compare against the model, plus invariants on both instances.
  logic [4:0] lnz1 = '0; int zr1 = 0;
  logic [7:0] lnz8 = '0; int zr8 = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_tgate", 32'(tg), 32'(m_tg));
      chk("model_cur_sel", 32'(cur), 32'(m_cur));
      chk("model_busy", 32'(busy), 32'(m_act));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_sel_err", 32'(err), 32'(m_err));
      chk("onehot0_5", 32'($countones(tg) <= 1), 32'(1));
      chk("onehot0_8", 32'($countones(tg8) <= 1), 32'(1));
      chk("sel_err_8", 32'(err8), 32'(0));
      if (m_rst_edge) begin
        lnz1 = tg; zr1 = 0; lnz8 = tg8; zr8 = 0;
      end else begin
        if (tg != 0) begin
          if (lnz1 != 0 && tg != lnz1) chk("bbm_gap_5", 32'(zr1 >= BBM), 32'(1));
          lnz1 = tg; zr1 = 0;
        end else zr1++;
        if (tg8 != 0) begin
          if (lnz8 != 0 && tg8 != lnz8) chk("bbm_gap_8", 32'(zr8 >= 1), 32'(1));
          lnz8 = tg8; zr8 = 0;
        end else zr8++;
      end
    end
  end

  a_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(tg))
    else $error("FAIL sva_onehot0 tgate=%b", tg);

  // Independent random select stream for the 8-tap instance.
  always @(negedge clk) sel8 = 3'($urandom_range(0, 7));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(nm, 32'(seen), 32'(1));
  endtask

  task automatic settle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !done && int'(cur) == map_sel(int'(sel))) ok = 1;
    end
    chk(nm, 32'(ok), 32'(1));
  endtask

  initial begin
    // Reset
    step(2);
    rstn = 1'b1;
    chk("rst_tgate", 32'(tg), 32'(5'b00010));
    chk("rst_cur", 32'(cur), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    step(3);
    chk("idle_hold", 32'(tg), 32'(5'b00010));

    // Normal switch 1 -> 4
    sel = 3'd4;
    step(1);
    chk("brk_e0_tgate", 32'(tg), 32'(0));
    chk("brk_e0_busy", 32'(busy), 32'(1));
    for (int k = 1; k < 4; k++) begin
      step(1);
      chk("brk_tgate", 32'(tg), 32'(0));
    end
    step(1);
    chk("make_tgate", 32'(tg), 32'(5'b10000));
    chk("make_cur", 32'(cur), 32'(4));
    for (int k = 5; k < 12; k++) begin
      step(1);
      chk("settle_busy", 32'(busy), 32'(1));
      chk("settle_nodone", 32'(done), 32'(0));
    end
    step(1);
    chk("done_pulse", 32'(done), 32'(1));
    chk("done_busy", 32'(busy), 32'(0));
    step(1);
    chk("done_single", 32'(done), 32'(0));

    // Out-of-range select from tap 3
    sel = 3'd3;
    settle("settle_to3");
    sel = 3'd7;
    step(1);
    chk("oor_err", 32'(err), 32'(1));
    chk("oor_busy", 32'(busy), 32'(1));
    wait_done("oor_done");
    chk("oor_tgate", 32'(tg), 32'(5'b00010));
    chk("oor_cur", 32'(cur), 32'(1));
    sel = 3'd3;
    step(1);
    chk("err_sticky", 32'(err), 32'(1));
    settle("settle_back3");
    sel = 3'd7; clr = 1'b1;
    step(1);
    chk("err_set_wins", 32'(err), 32'(1));
    sel = 3'd3;
    step(1);
    chk("err_cleared", 32'(err), 32'(0));
    clr = 1'b0;
    settle("settle_after_clr");

    // Mid-switch change 1 -> 2, then 0 during break
    sel = 3'd1;
    settle("settle_to1");
    sel = 3'd2;
    step(2);
    sel = 3'd0;
    wait_done("mid_done");
    chk("mid_tgate", 32'(tg), 32'(5'b00100));
    step(1);
    chk("mid_restart", 32'(tg), 32'(0));
    chk("mid_restart_busy", 32'(busy), 32'(1));
    settle("mid_settle0");
    chk("mid_final", 32'(tg), 32'(5'b00001));

    // Reset during settle
    sel = 3'd3;
    step(7);
    chk("pre_rst_settle", 32'(tg), 32'(5'b01000));
    rstn = 1'b0;
    step(1);
    chk("midrst_tgate", 32'(tg), 32'(5'b00010));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    sel = 3'd1;
    rstn = 1'b1;
    step(2);

    // Random select sequence
    for (int i = 0; i < 60; i++) begin
      sel = 3'($urandom_range(0, 7));
      clr = 1'($urandom_range(0, 1));
      step($urandom_range(1, 20));
    end
    clr = 1'b0;
    sel = 3'd1;
    settle("final_settle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ref_clk_tap_switch.md
Name: ref_clk_tap_switch

Overview:
Parametrised successor to the reference-clock divider tap decoder. Drives a one-hot transmission-gate enable bus selecting one of NUM_TAPS divider taps. On a tap change it inserts a programmable break-before-make dead time (all gates off), then a settle window, so two divider taps are never shorted together. Sits between the configuration register bank (same clock domain) and the analog tgate array.

Parameters:
NUM_TAPS, 5, number of divider taps / tgate enables; bit i enables tap i (bit 0 = /512 … bit 4 = /32 at default)
SEL_W, 3, width of ref_clk_sel; NUM_TAPS <= 2**SEL_W required
DEFAULT_TAP, 1, tap used at reset and for out-of-range selects (1 = /256)
BBM_CYCLES, 4, dead-time cycles with all gates off; must be >= 1
SETTLE_CYCLES, 8, cycles after make before switch reported complete; must be >= 1

Ports:
clk  input  1  block clock
rstn  input  1  synchronous reset, active-low
ref_clk_sel  input  SEL_W  requested tap index, synchronous to clk, level-sampled
err_clr  input  1  clears sel_err
tgate_control  output  NUM_TAPS  registered one-hot (or all-zero during break) tgate enables
cur_sel  output  SEL_W  index of tap currently enabled / being made
busy  output  1  high from switch start until switch_done
switch_done  output  1  single-cycle pulse at end of settle
sel_err  output  1  sticky: an out-of-range select was seen

Behaviour:
- Reset (rstn low at posedge): state IDLE; tgate_control = one-hot(DEFAULT_TAP); cur_sel = DEFAULT_TAP; busy = 0; switch_done = 0; sel_err = 0; counter = 0. Reset mid-switch aborts immediately to these values.
- Mapping: tgt = ref_clk_sel if ref_clk_sel < NUM_TAPS, else DEFAULT_TAP. Evaluated every cycle; only acted on in IDLE.
- sel_err: set on any cycle ref_clk_sel >= NUM_TAPS (any state); cleared by err_clr; set wins over clear in the same cycle.
- FSM IDLE: if tgt != cur_sel at posedge E0: latch target, tgate_control <= 0, busy <= 1, cnt <= BBM_CYCLES-1, -> BREAK. Otherwise hold outputs.
- BREAK: tgate_control all-zero for exactly BBM_CYCLES cycles. When cnt == 0: tgate_control <= one-hot(target), cur_sel <= target, cnt <= SETTLE_CYCLES-1, -> SETTLE; else cnt--.
- SETTLE: new tap enabled. When cnt == 0: busy <= 0, switch_done <= 1 (one cycle), -> IDLE; else cnt--.
- Latency: sel change sampled at E0 → gates off at E0 → new tap on at E0+BBM_CYCLES → busy low and switch_done high at E0+BBM_CYCLES+SETTLE_CYCLES.
- ref_clk_sel changes during BREAK/SETTLE are ignored; target is not retargeted. On return to IDLE the current tgt is re-evaluated, so the last value wins and a fresh switch may start on the cycle after switch_done.
- Changing back to the original tap mid-switch still completes the latched switch, then switches back.
- Invariant: popcount(tgate_control) <= 1 every cycle; there is never a cycle with two gates enabled and never a direct one-hot-to-one-hot transition.
- Out-of-range select while cur_sel == DEFAULT_TAP: no switch, sel_err only.

Test Plan:
- Reset: rstn low 2 cycles, then release with ref_clk_sel=1 -> tgate_control=5'b00010, cur_sel=1, busy=0, no switch_done.
- Normal switch: sel 1→4 -> tgate 0 for exactly 4 cycles, then 5'b10000; switch_done pulse 12 cycles after the sampling edge; busy high for exactly 12 cycles.
- Out-of-range: sel=7 from tap 3 -> switch to tap 1 (5'b00010) via full break/settle; sel_err=1, held after sel returns to 3; err_clr with sel=7 keeps sel_err=1; err_clr with sel=3 clears it.
- Mid-switch change: sel 1→2, then 2→0 during BREAK -> completes to 5'b00100, done pulse, next cycle starts switch to 5'b00001.
- Reset mid-switch: rstn low during SETTLE -> next edge gives tgate 5'b00010, busy 0, no done pulse.
- Random sel sequence with SVA: onehot0(tgate_control) always; tgate never moves between two different non-zero values without >= BBM_CYCLES zero cycles between them. Repeat with NUM_TAPS=8, SEL_W=3, BBM=1, SETTLE=1.
